// File: rtl/coa_input_pkg.sv
// Shared types and constants for the Basys 3 operator input path.
// Entry-state encoding is fixed so the exposed state can be decoded externally.
package coa_input_pkg;

    localparam int DEBOUNCE_10MS = 1_000_000;
    localparam int SW_W          = 16;

    typedef enum logic [1:0] {
        S_LO   = 2'b00,
        S_HI   = 2'b01,
        S_DONE = 2'b10
    } entry_state_t;

endpackage

// File: rtl/button_debounce.sv
// One push-button path: 2-flop synchroniser, stability counter and a
// registered rising-edge detect producing a single-cycle press pulse.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    logic             sync_1;
    logic             sync_2;
    logic             level;
    logic             level_q;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= btn;
            sync_2 <= sync_1;
        end
    end

    // Any cycle of agreement restarts the count, so short glitches never land.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sync_2 == level) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            cnt   <= '0;
            level <= sync_2;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= 1'b0;
            press   <= 1'b0;
        end else begin
            level_q <= level;
            press   <= level & ~level_q;
        end
    end

endmodule

// File: rtl/switch_word_entry.sv
// Builds a 32-bit word from the 16 slide switches in two halves, driven by
// debounced load/clear buttons; exposes the half select and a completion pulse.
module switch_word_entry
    import coa_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
    parameter int CNT_W           = 20
) (
    input  logic            clock_100Mhz,
    input  logic            reset,
    input  logic [SW_W-1:0] sw,
    input  logic            btn_load,
    input  logic            btn_clear,
    output logic [31:0]     entered_number,
    output logic            p,
    output logic            word_valid,
    output logic [1:0]      state
);

    logic [SW_W-1:0] sw_sync_1;
    logic [SW_W-1:0] sw_sync_2;
    logic            load_press;
    logic            clear_press;

    entry_state_t    state_q;
    entry_state_t    state_d;
    logic [31:0]     word_d;
    logic            valid_d;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_load (
        .clk  (clock_100Mhz),
        .rst  (reset),
        .btn  (btn_load),
        .press(load_press)
    );

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_clear (
        .clk  (clock_100Mhz),
        .rst  (reset),
        .btn  (btn_clear),
        .press(clear_press)
    );

    // Switches are only sampled at commit, so a plain bus synchroniser suffices.
    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            sw_sync_1 <= '0;
            sw_sync_2 <= '0;
        end else begin
            sw_sync_1 <= sw;
            sw_sync_2 <= sw_sync_1;
        end
    end

    always_comb begin
        state_d = state_q;
        word_d  = entered_number;
        valid_d = 1'b0;
        if (clear_press) begin
            state_d = S_LO;
            word_d  = '0;
        end else if (load_press) begin
            case (state_q)
                S_LO: begin
                    word_d[15:0] = sw_sync_2;
                    state_d      = S_HI;
                end
                S_HI: begin
                    word_d[31:16] = sw_sync_2;
                    valid_d       = 1'b1;
                    state_d       = S_DONE;
                end
                S_DONE: begin
                    word_d  = {16'h0000, sw_sync_2};
                    state_d = S_HI;
                end
                default: begin
                    word_d  = '0;
                    state_d = S_LO;
                end
            endcase
        end
    end

    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            state_q        <= S_LO;
            entered_number <= '0;
            word_valid     <= 1'b0;
            p              <= 1'b0;
        end else begin
            state_q        <= state_d;
            entered_number <= word_d;
            word_valid     <= valid_d;
            p              <= (state_d == S_HI);
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_switch_word_entry.sv
// Self-checking bench for switch_word_entry with a short debounce window;
// expectations come from an abstract two-half word-entry model.
module tb_switch_word_entry;
    import coa_input_pkg::*;

    localparam int D   = 4;
    localparam int LAT = D + 4;

    logic        clock_100Mhz;
    logic        reset;
    logic [15:0] sw;
    logic        btn_load;
    logic        btn_clear;
    logic [31:0] entered_number;
    logic        p;
    logic        word_valid;
    logic [1:0]  state;

    int n_checks;
    int n_fails;

    // Reference model: phase 0 = awaiting low half, 1 = awaiting high half,
    // 2 = word complete.
    logic [31:0] model_word;
    int          model_phase;

    switch_word_entry #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (3)
    ) dut (
        .clock_100Mhz  (clock_100Mhz),
        .reset         (reset),
        .sw            (sw),
        .btn_load      (btn_load),
        .btn_clear     (btn_clear),
        .entered_number(entered_number),
        .p             (p),
        .word_valid    (word_valid),
        .state         (state)
    );

    initial clock_100Mhz = 1'b0;
    always #5 clock_100Mhz = ~clock_100Mhz;

    function automatic logic [1:0] phase_state(input int ph);
        case (ph)
            0:       return S_LO;
            1:       return S_HI;
            default: return S_DONE;
        endcase
    endfunction

    // Drive one button event, check the commit lands exactly LAT edges later,
    // keep the buttons held for extra cycles, then release and let it settle.
    task automatic do_press(input logic ld, input logic cl,
                            input logic [15:0] sw_val, input int hold);
        logic [31:0] prev_word;
        logic        exp_valid;
        int          wv_seen;
        prev_word = model_word;
        exp_valid = 1'b0;
        wv_seen   = 0;
        @(negedge clock_100Mhz);
        sw        = sw_val;
        btn_load  = ld;
        btn_clear = cl;
        if (cl) begin
            model_word  = '0;
            model_phase = 0;
        end else if (ld) begin
            if (model_phase == 0) begin
                model_word[15:0] = sw_val;
                model_phase      = 1;
            end else if (model_phase == 1) begin
                model_word[31:16] = sw_val;
                model_phase       = 2;
                exp_valid         = 1'b1;
            end else begin
                model_word  = {16'h0000, sw_val};
                model_phase = 1;
            end
        end
        for (int i = 1; i < LAT; i++) begin
            @(negedge clock_100Mhz);
            if (word_valid) wv_seen++;
        end
        n_checks++;
        if (entered_number !== prev_word || wv_seen != 0) begin
            n_fails++;
            $display("FAIL early_commit: word=%h valid_pulses=%0d, required word=%h valid_pulses=0",
                     entered_number, wv_seen, prev_word);
        end
        @(negedge clock_100Mhz);
        n_checks++;
        if (entered_number !== model_word) begin
            n_fails++;
            $display("FAIL commit_word: got %h required %h", entered_number, model_word);
        end
        n_checks++;
        if (p !== (model_phase == 1) || state !== phase_state(model_phase)) begin
            n_fails++;
            $display("FAIL commit_p_state: p=%b state=%b required p=%b state=%b",
                     p, state, (model_phase == 1), phase_state(model_phase));
        end
        n_checks++;
        if (word_valid !== exp_valid) begin
            n_fails++;
            $display("FAIL commit_valid: got %b required %b", word_valid, exp_valid);
        end
        wv_seen = 0;
        for (int i = 0; i < hold + 1; i++) begin
            @(negedge clock_100Mhz);
            if (word_valid) wv_seen++;
        end
        btn_load  = 1'b0;
        btn_clear = 1'b0;
        for (int i = 0; i < 2 * D + 4; i++) begin
            @(negedge clock_100Mhz);
            if (word_valid) wv_seen++;
        end
        n_checks++;
        if (entered_number !== model_word || wv_seen != 0 || p !== (model_phase == 1)) begin
            n_fails++;
            $display("FAIL after_release: word=%h p=%b extra_valid=%0d required word=%h p=%b extra_valid=0",
                     entered_number, p, wv_seen, model_word, (model_phase == 1));
        end
    endtask

    task automatic test_reset;
        reset     = 1'b1;
        btn_load  = 1'b0;
        btn_clear = 1'b0;
        sw        = 16'h0000;
        model_word  = '0;
        model_phase = 0;
        repeat (3) @(negedge clock_100Mhz);
        n_checks++;
        if (entered_number !== 32'h0 || p !== 1'b0 || word_valid !== 1'b0 || state !== S_LO) begin
            n_fails++;
            $display("FAIL reset_values: word=%h p=%b valid=%b state=%b required all zero",
                     entered_number, p, word_valid, state);
        end
        reset = 1'b0;
        do_press(1'b1, 1'b0, 16'hA5A5, 2);
        // Reset in the middle of a debounce count with the button held.
        @(negedge clock_100Mhz);
        sw       = 16'h1111;
        btn_load = 1'b1;
        repeat (3) @(negedge clock_100Mhz);
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (entered_number !== 32'h0 || p !== 1'b0 || word_valid !== 1'b0 || state !== S_LO) begin
            n_fails++;
            $display("FAIL reset_mid_count: word=%h p=%b valid=%b state=%b required all zero",
                     entered_number, p, word_valid, state);
        end
        model_word  = '0;
        model_phase = 0;
        repeat (2) @(negedge clock_100Mhz);
        reset = 1'b0;
        for (int i = 1; i < LAT; i++) @(negedge clock_100Mhz);
        n_checks++;
        if (entered_number !== 32'h0) begin
            n_fails++;
            $display("FAIL reset_release_early: got %h required 00000000", entered_number);
        end
        @(negedge clock_100Mhz);
        model_word[15:0] = 16'h1111;
        model_phase      = 1;
        n_checks++;
        if (entered_number !== model_word || p !== 1'b1) begin
            n_fails++;
            $display("FAIL reset_release_load: word=%h p=%b required %h p=1",
                     entered_number, p, model_word);
        end
        btn_load = 1'b0;
        repeat (2 * D + 4) @(negedge clock_100Mhz);
    endtask

    task automatic test_full_entry;
        do_press(1'b0, 1'b1, 16'h0000, 0);
        do_press(1'b1, 1'b0, 16'hBEEF, 0);
        do_press(1'b1, 1'b0, 16'hDEAD, 0);
        n_checks++;
        if (entered_number !== 32'hDEADBEEF) begin
            n_fails++;
            $display("FAIL full_entry_word: got %h required deadbeef", entered_number);
        end
    endtask

    task automatic test_restart;
        do_press(1'b1, 1'b0, 16'h0001, 0);
        n_checks++;
        if (entered_number !== 32'h00000001 || p !== 1'b1) begin
            n_fails++;
            $display("FAIL restart: word=%h p=%b required 00000001 p=1", entered_number, p);
        end
    endtask

    task automatic test_bounce;
        int wv_seen;
        wv_seen = 0;
        @(negedge clock_100Mhz);
        sw = 16'hFFFF;
        for (int i = 0; i < 10; i++) begin
            btn_load = ~btn_load;
            repeat (2) begin
                @(negedge clock_100Mhz);
                if (word_valid) wv_seen++;
            end
        end
        btn_load = 1'b0;
        repeat (2 * D + 4) begin
            @(negedge clock_100Mhz);
            if (word_valid) wv_seen++;
        end
        n_checks++;
        if (entered_number !== model_word || p !== (model_phase == 1) || wv_seen != 0) begin
            n_fails++;
            $display("FAIL bounce: word=%h p=%b pulses=%0d required word=%h p=%b pulses=0",
                     entered_number, p, wv_seen, model_word, (model_phase == 1));
        end
    endtask

    task automatic test_clear_priority;
        do_press(1'b0, 1'b1, 16'h0000, 0);
        do_press(1'b1, 1'b0, 16'h1234, 0);
        do_press(1'b1, 1'b1, 16'h5678, 0);
        n_checks++;
        if (entered_number !== 32'h0 || state !== S_LO) begin
            n_fails++;
            $display("FAIL clear_priority: word=%h state=%b required 00000000 state=%b",
                     entered_number, state, S_LO);
        end
    endtask

    task automatic test_held;
        do_press(1'b0, 1'b1, 16'h0000, 0);
        // Held 100 cycles in total; sw changes mid-hold must not re-commit.
        fork
            begin
                repeat (LAT + 20) @(negedge clock_100Mhz);
                sw = 16'h9999;
            end
        join_none
        do_press(1'b1, 1'b0, 16'h4321, 100 - LAT);
        n_checks++;
        if (entered_number !== 32'h00004321 || p !== 1'b1) begin
            n_fails++;
            $display("FAIL held: word=%h p=%b required 00004321 p=1", entered_number, p);
        end
    endtask

    task automatic test_random;
        logic ld;
        logic cl;
        for (int i = 0; i < 16; i++) begin
            cl = ($urandom_range(0, 3) == 0);
            ld = cl ? ($urandom_range(0, 1) == 1) : 1'b1;
            do_press(ld, cl, 16'($urandom_range(0, 65535)), $urandom_range(0, 6));
        end
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        test_reset;
        test_full_entry;
        test_restart;
        test_bounce;
        test_clear_priority;
        test_held;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/switch_word_entry.md
# switch_word_entry

Operator input path for the Basys 3 board: the counterpart to the seven-segment display driver. It builds a 32-bit value from the 16 slide switches in two halves, using two debounced push-buttons. It exposes the word, a half-select `p` and a one-cycle completion pulse, so the display driver can show the half being edited and downstream logic can consume the finished word.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles required before a button level is accepted (10 ms at 100 MHz); legal range 2..2^20.
- `CNT_W`, default 20: debounce counter width; must satisfy 2^CNT_W ≥ DEBOUNCE_CYCLES.

Ports:
- `clock_100Mhz`, in, 1: the single clock, 100 MHz.
- `reset`, in, 1: asynchronous, active-high reset.
- `sw`, in, 16: raw slide switches, asynchronous to the clock.
- `btn_load`, in, 1: raw load button; bouncing, asynchronous, active-high.
- `btn_clear`, in, 1: raw clear button; bouncing, asynchronous, active-high.
- `entered_number`, out, 32: assembled word.
- `p`, out, 1: half select for the display. 0 means lower half [15:0]; 1 means upper half [31:16].
- `word_valid`, out, 1: one-cycle pulse when the upper half is committed.

## Operation
- **Synchronisers.**
  - Each button passes through a 2-flop synchroniser.
  - `sw` passes through a 16-bit 2-flop synchroniser. It is sampled only at commit, so it is treated as quasi-static.
- **Debounce, per button.**
  - A counter increments on every cycle where the synced level ≠ the debounced level.
  - The counter clears to 0 on any cycle where they are equal.
  - When the counter = DEBOUNCE_CYCLES−1 and the levels still differ: the debounced level takes the synced level, and the counter clears.
- **Press pulse.** A registered, one-cycle rising-edge detect on the debounced level. A held button yields exactly one press, and release generates nothing.
- **State machine.** States are S_LO, S_HI and S_DONE.
  - S_LO, load press: `entered_number[15:0]` ← synced `sw`; go to S_HI.
  - S_HI, load press: `entered_number[31:16]` ← synced `sw`; `word_valid` = 1 for one cycle; go to S_DONE.
  - S_DONE, load press: `[15:0]` ← `sw` and `[31:16]` ← 0; go to S_HI. This starts a new word.
  - Clear press in any state: `entered_number` ← 0; go to S_LO; no `word_valid`.
  - Clear and load press in the same cycle: clear wins.
- **`p` output.** A registered decode of the next state: 1 in S_HI, 0 in S_LO and S_DONE.
- **Reset values.**
  - `entered_number` = 0, `p` = 0, `word_valid` = 0, state = S_LO.
  - Synchroniser flops, debounced levels, counters and press pulses are all 0.
- **Reset mid-operation.** Reset discards partial debounce counts and any half-entered word; no press is generated on release of reset.

## Timing
- Raw button edge captured at clock edge k:
  - synced level changes at k+2;
  - debounced level changes at k+1+DEBOUNCE_CYCLES+1;
  - press pulse is high for the following cycle;
  - `entered_number`, `p` and state update on the edge after the press. Total latency is DEBOUNCE_CYCLES+4 cycles.
- `word_valid` is registered and coincides with the cycle `entered_number[31:16]` first shows the new value.
- Bounce: any synced glitch shorter than DEBOUNCE_CYCLES cycles produces no level change and no press.
- Minimum press spacing is 2·DEBOUNCE_CYCLES cycles, because release must also debounce.
- `sw` value committed: the synced value present in the press cycle, i.e. the raw `sw` from 2 cycles earlier.

## Structure
- **Shared package `coa_input_pkg`:**
  - state typedef `entry_state_t` (S_LO=2'b00, S_HI=2'b01, S_DONE=2'b10);
  - `DEBOUNCE_10MS` = 1_000_000;
  - `SW_W` = 16.
- **Sub-module `button_debounce`.** Parameters DEBOUNCE_CYCLES and CNT_W. It contains the synchroniser, counter and edge detect, and outputs a `press` pulse. It is instantiated twice.
- **Top level.** Holds the `sw` synchroniser, the FSM and the output registers. Expected size is about 200 lines total.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4.
1. **Reset.** Assert `reset` mid-count with `btn_load` high → all outputs 0 and state S_LO. After deassert with `btn_load` still high: one press after 4 stable cycles, then `[15:0]` loads `sw`.
2. **Full entry.** `sw`=16'hBEEF, press load; `sw`=16'hDEAD, press load → `entered_number`=32'hDEADBEEF. `word_valid` is high exactly 1 cycle, DEBOUNCE_CYCLES+4 cycles after the second raw edge. `p` sequence 0→1→0.
3. **Bounce rejection.** `btn_load` toggles every 2 cycles for 20 cycles, then returns low → no press, `entered_number` unchanged, `p` unchanged.
4. **Clear priority.** In S_HI with `[15:0]`=16'h1234, raise both buttons on the same edge → `entered_number`=0, state S_LO, no `word_valid`.
5. **Restart from S_DONE.** With 32'hDEADBEEF, `sw`=16'h0001, press load → `entered_number`=32'h00000001, `p`=1.
6. **Held button.** Hold `btn_load` for 100 cycles → exactly one press and one half committed.
